// File: rtl/sb_pkg.sv
// Shared definitions for the round-robin system bus: size encodings,
// default address map, response-state encoding and lane helper functions.
package sb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [63:0] DEF_SLV_BASE = {32'h0000_1000, 32'h0000_0000};
    localparam logic [63:0] DEF_SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000};

    typedef enum logic {ST_IDLE, ST_RESP} rsp_state_t;

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Shift the addressed lane down to bit 0, then zero- or sign-extend it.
    function automatic logic [31:0] rdata_ext(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [1:0] size, input logic un_sign);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lo, 3'b000};
        case (size)
            SZ_BYTE: res = un_sign ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = un_sign ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            SZ_WORD: res = sh;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sb_rr_arb.sv
// NM-wide round-robin arbiter: the first requester at or after the pointer
// wins, and the pointer moves just past the winner on every grant.
module sb_rr_arb
    import sb_pkg::*;
#(
    parameter int NM = 2,
    parameter int MW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NM-1:0] req,
    output logic [NM-1:0] gnt,
    output logic          gnt_any,
    output logic [MW-1:0] gnt_idx
);

    logic [MW-1:0] ptr;

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NM; i++) begin
            idx = (int'(ptr) + i) % NM;
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = MW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (int'(gnt_idx) == NM - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sb_rr_bus.sv
// Shared single-issue bus: NM masters to NS slaves with round-robin
// arbitration, address decode, lane steering and a one-deep response stage.
module sb_rr_bus
    import sb_pkg::*;
#(
    parameter int NM = 2,
    parameter int NS = 2,
    parameter int AW = 32,
    parameter logic [NS*AW-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NS*AW-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_req,
    input  logic [NM-1:0]    m_we,
    input  logic [NM-1:0]    m_un_sign,
    input  logic [2*NM-1:0]  m_size,
    input  logic [NM*AW-1:0] m_addr,
    input  logic [32*NM-1:0] m_wdata,
    output logic [NM-1:0]    m_gnt,
    output logic [NM-1:0]    m_rvalid,
    output logic [31:0]      m_rdata,
    output logic [NM-1:0]    m_err,
    output logic [NS-1:0]    s_sel,
    output logic             s_we,
    output logic [3:0]       s_be,
    output logic [AW-1:0]    s_addr,
    output logic [31:0]      s_wdata,
    input  logic [32*NS-1:0] s_rdata
);

    localparam int MW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    logic          gnt_any;
    logic [MW-1:0] gnt_idx;
    logic [AW-1:0] addr, offset;
    logic [1:0]    size;
    logic          we, un_sign;
    logic [31:0]   wdata;
    logic          hit_any, misalign, acc_err, acc_ok;
    logic [SW-1:0] slv_idx;

    rsp_state_t    state_q, state_d;
    logic [MW-1:0] rsp_master;
    logic [SW-1:0] rsp_slave;
    logic [1:0]    rsp_lo, rsp_size;
    logic          rsp_un_sign, rsp_err, rsp_valid;

    // Reset masks requests so that nothing is granted while it is held.
    sb_rr_arb #(.NM(NM), .MW(MW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (m_req & {NM{~rst}}),
        .gnt     (m_gnt),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        addr    = m_addr[int'(gnt_idx)*AW +: AW];
        size    = m_size[int'(gnt_idx)*2 +: 2];
        we      = m_we[gnt_idx];
        un_sign = m_un_sign[gnt_idx];
        wdata   = m_wdata[int'(gnt_idx)*32 +: 32];
    end

    // Scanning downwards lets the lowest-index hit overwrite any higher one.
    always_comb begin
        hit_any = 1'b0;
        slv_idx = '0;
        offset  = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            if ((addr & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW]) begin
                hit_any = 1'b1;
                slv_idx = SW'(s);
                offset  = addr & ~SLV_MASK[s*AW +: AW];
            end
        end
    end

    always_comb begin
        misalign = ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        acc_err  = !hit_any || misalign || (size == SZ_RSVD);
        acc_ok   = gnt_any && !acc_err;
        s_sel    = '0;
        if (acc_ok) s_sel[slv_idx] = 1'b1;
        s_we     = acc_ok && we;
        s_be     = acc_ok ? be_gen(size, addr[1:0]) : 4'b0000;
        s_addr   = acc_ok ? (offset & ~AW'(3)) : '0;
        s_wdata  = 32'h0;
        if (acc_ok && we) begin
            case (size)
                SZ_BYTE: s_wdata = {4{wdata[7:0]}};
                SZ_HALF: s_wdata = {2{wdata[15:0]}};
                default: s_wdata = wdata;
            endcase
        end
    end

    always_comb begin
        state_d = (gnt_any && !we) ? ST_RESP : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsp_err     <= 1'b0;
            rsp_master  <= '0;
            rsp_slave   <= '0;
            rsp_lo      <= 2'b00;
            rsp_size    <= 2'b00;
            rsp_un_sign <= 1'b0;
        end else begin
            state_q <= state_d;
            rsp_err <= gnt_any && acc_err;
            if (gnt_any) begin
                rsp_master  <= gnt_idx;
                rsp_slave   <= slv_idx;
                rsp_lo      <= addr[1:0];
                rsp_size    <= size;
                rsp_un_sign <= un_sign;
            end
        end
    end

    // Responses come from registered state; reset suppresses one in flight.
    always_comb begin
        rsp_valid = (state_q == ST_RESP);
        m_rvalid  = '0;
        m_err     = '0;
        m_rdata   = 32'h0;
        if (!rst) begin
            if (rsp_valid) m_rvalid[rsp_master] = 1'b1;
            if (rsp_err)   m_err[rsp_master]    = 1'b1;
            if (rsp_valid && !rsp_err)
                m_rdata = rdata_ext(s_rdata[int'(rsp_slave)*32 +: 32], rsp_lo, rsp_size, rsp_un_sign);
        end
    end

endmodule
